pipe_hazard_unit: RTL and testbench

//  Central hazard/forwarding controller for the 5-stage pipelined core; replaces ad-hoc HazardDetect/ForwardUnit.

---
 rtl/pipe_hazard_unit_pkg.sv | 7 +
 rtl/pipe_hazard_unit_fwd_match.sv | 20 ++
 rtl/pipe_hazard_unit.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// pipe_hazard_unit_pkg: forwarding-select encodings and hazard FSM state codes.
package pipe_hazard_unit_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic [1:0] {HZ_IDLE, HZ_MDU_BUSY, HZ_MEM_WAIT} hz_state_t;
endpackage

// File: rtl/pipe_hazard_unit_fwd_match.sv
// pipe_hazard_unit_fwd_match: one EX source vs MEM/WB destinations -> 2-bit forward select.
module pipe_hazard_unit_fwd_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_mem_valid,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_regwrite,
  input  logic              i_wb_valid,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_regwrite,
  output logic [1:0]        o_sel
);
  logic w_mem_hit, w_wb_hit;
  assign w_mem_hit = i_mem_valid & i_mem_regwrite & (i_mem_rd != '0) & (i_mem_rd == i_rs);
  assign w_wb_hit  = i_wb_valid & i_wb_regwrite & (i_wb_rd != '0) & (i_wb_rd == i_rs);
  assign o_sel     = w_mem_hit ? FWD_MEM : w_wb_hit ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: stall/flush/forward control for the 5-stage core.
// Define PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int NUM_SRC     = 2,
  parameter int MDU_LAT     = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] i_id_rs,
  input  logic [NUM_SRC-1:0]        i_id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0] i_ex_rs,
  input  logic                      i_ex_valid,
  input  logic [REG_AW-1:0]         i_ex_rd,
  input  logic                      i_ex_regwrite,
  input  logic                      i_ex_memread,
  input  logic                      i_ex_is_mdu,
  input  logic                      i_mem_valid,
  input  logic [REG_AW-1:0]         i_mem_rd,
  input  logic                      i_mem_regwrite,
  input  logic                      i_wb_valid,
  input  logic [REG_AW-1:0]         i_wb_rd,
  input  logic                      i_wb_regwrite,
  input  logic                      i_br_taken,
  input  logic                      i_dmem_req,
  input  logic                      i_dmem_ready,
  output logic                      o_pc_we,
  output logic                      o_if_id_we,
  output logic                      o_id_ex_we,
  output logic                      o_ex_mem_we,
  output logic                      o_mem_wb_we,
  output logic                      o_if_id_flush,
  output logic                      o_id_ex_flush,
  output logic                      o_ex_mem_flush,
  output logic                      o_mem_wb_flush,
  output logic [2*NUM_SRC-1:0]      o_fwd_sel,
  output logic                      o_mdu_busy,
  output logic                      o_mem_err,
  output logic [31:0]               o_perf_stall,
  output logic [31:0]               o_perf_flush
);
  localparam int MCW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MCW-1:0] MDU_INIT = MCW'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);
  hz_state_t      r_state, w_state_nxt;
  logic [MCW-1:0] r_mdu_cnt, w_mdu_cnt_nxt;
  logic [WCW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic           r_mem_err;
  logic [NUM_SRC-1:0] w_lu_hit;
  logic w_mem_stall, w_mdu_start, w_mdu_busy_st, w_mdu_hold, w_mdu_act;
  logic w_load_use, w_branch, w_lu;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_lu_hit[g] = i_id_rs_used[g] & (i_id_rs[g*REG_AW +: REG_AW] == i_ex_rd);
    pipe_hazard_unit_fwd_match #(.REG_AW(REG_AW)) u_fwd (
      .i_rs           (i_ex_rs[g*REG_AW +: REG_AW]),
      .i_mem_valid    (i_mem_valid),
      .i_mem_rd       (i_mem_rd),
      .i_mem_regwrite (i_mem_regwrite),
      .i_wb_valid     (i_wb_valid),
      .i_wb_rd        (i_wb_rd),
      .i_wb_regwrite  (i_wb_regwrite),
      .o_sel          (o_fwd_sel[2*g +: 2])
    );
  end
  // Priority: memory wait, then MDU occupancy, then branch, then load-use.
  assign w_mem_stall   = i_dmem_req & ~i_dmem_ready;
  assign w_mdu_busy_st = (r_state == HZ_MDU_BUSY);
  assign w_mdu_start   = ~w_mdu_busy_st & ~w_mem_stall & i_ex_valid & i_ex_is_mdu & (MDU_LAT > 1);
  assign w_mdu_hold    = w_mdu_busy_st & (r_mdu_cnt != '0);
  assign w_mdu_act     = w_mdu_start | w_mdu_hold;
  assign w_load_use    = i_ex_valid & i_ex_memread & i_ex_regwrite & (i_ex_rd != '0) & (|w_lu_hit);
  assign w_branch      = i_br_taken & ~w_mem_stall & ~w_mdu_act;
  assign w_lu          = w_load_use & ~w_mem_stall & ~w_mdu_act & ~i_br_taken;
  // Reset forces every stage open and no bubbles, independent of state.
  assign o_pc_we        = ~i_rst_n | ~(w_mem_stall | w_mdu_act | w_lu);
  assign o_if_id_we     = ~i_rst_n | ~(w_mem_stall | w_mdu_act | w_lu);
  assign o_id_ex_we     = ~i_rst_n | ~(w_mem_stall | w_mdu_act);
  assign o_ex_mem_we    = ~i_rst_n | ~w_mem_stall;
  assign o_mem_wb_we    = 1'b1;
  assign o_if_id_flush  = i_rst_n & w_branch;
  assign o_id_ex_flush  = i_rst_n & (w_branch | w_lu);
  assign o_ex_mem_flush = i_rst_n & ~w_mem_stall & w_mdu_act;
  assign o_mem_wb_flush = i_rst_n & w_mem_stall;
  assign o_mdu_busy     = i_rst_n & (w_mdu_start | w_mdu_busy_st);
  assign o_mem_err      = r_mem_err;
  always_comb begin
    w_state_nxt    = r_state;
    w_mdu_cnt_nxt  = r_mdu_cnt;
    w_wait_cnt_nxt = ~w_mem_stall ? '0 : (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
    if (w_mdu_busy_st) begin
      w_mdu_cnt_nxt = (r_mdu_cnt != '0) ? r_mdu_cnt - 1'b1 : r_mdu_cnt;
      w_state_nxt   = (r_mdu_cnt == '0 && !w_mem_stall) ? HZ_IDLE : HZ_MDU_BUSY;
    end else if (w_mem_stall) begin
      w_state_nxt = HZ_MEM_WAIT;
    end else if (w_mdu_start) begin
      w_state_nxt   = HZ_MDU_BUSY;
      w_mdu_cnt_nxt = MDU_INIT;
    end else begin
      w_state_nxt = HZ_IDLE;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= HZ_IDLE;
      r_mdu_cnt  <= '0;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mdu_cnt  <= w_mdu_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= r_mem_err | (w_mem_stall & (w_wait_cnt_nxt == WAIT_MAX));
    end
  end
`ifdef PERF_CNT_EN
  logic [31:0] r_perf_stall, r_perf_flush;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      r_perf_stall <= r_perf_stall + {31'd0, ~o_pc_we};
      r_perf_flush <= r_perf_flush + {31'd0, w_branch};
    end
  end
  assign o_perf_stall = r_perf_stall;
  assign o_perf_flush = r_perf_flush;
`else
  assign o_perf_stall = '0;
  assign o_perf_flush = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed vectors for pipe_hazard_unit (MDU_LAT=8, MEM_TIMEOUT=2).
module tb_pipe_hazard_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  id_rs, ex_rs;
  logic [1:0]  id_rs_used;
  logic        ex_valid, ex_regwrite, ex_memread, ex_is_mdu;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        mem_valid, mem_regwrite, wb_valid, wb_regwrite;
  logic        br_taken, dmem_req, dmem_ready;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [3:0]  fwd_sel;
  logic        mdu_busy, mem_err;
  logic [31:0] perf_stall, perf_flush;
  logic [4:0]  we_v;
  logic [3:0]  fl_v;
  int n_cmp = 0;
  int n_err = 0;
  int busy_n, fl_n;
  int exp_stall, exp_flush;
  always #5 clk = ~clk;
  assign we_v = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we};
  assign fl_v = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  pipe_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .MDU_LAT(8), .MEM_TIMEOUT(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rs_used(id_rs_used), .i_ex_rs(ex_rs),
    .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread),
    .i_ex_is_mdu(ex_is_mdu), .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_mem_regwrite(mem_regwrite),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_regwrite(wb_regwrite), .i_br_taken(br_taken),
    .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready), .o_pc_we(pc_we), .o_if_id_we(if_id_we),
    .o_id_ex_we(id_ex_we), .o_ex_mem_we(ex_mem_we), .o_mem_wb_we(mem_wb_we), .o_if_id_flush(if_id_flush),
    .o_id_ex_flush(id_ex_flush), .o_ex_mem_flush(ex_mem_flush), .o_mem_wb_flush(mem_wb_flush),
    .o_fwd_sel(fwd_sel), .o_mdu_busy(mdu_busy), .o_mem_err(mem_err),
    .o_perf_stall(perf_stall), .o_perf_flush(perf_flush)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    id_rs = '0; ex_rs = '0; id_rs_used = '0;
    ex_valid = 0; ex_regwrite = 0; ex_memread = 0; ex_is_mdu = 0; ex_rd = '0;
    mem_valid = 0; mem_rd = '0; mem_regwrite = 0; wb_valid = 0; wb_rd = '0; wb_regwrite = 0;
    br_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic lw_x5_add();
    ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5;
    id_rs = {5'd1, 5'd5}; id_rs_used = 2'b11;
  endtask
  initial begin
    clr();
    rst_n = 0;
    dmem_req = 1; br_taken = 1; ex_valid = 1; ex_is_mdu = 1;
    cyc();
    chk("rst_we", 32'(we_v), 32'h1f);
    chk("rst_fl", 32'(fl_v), 32'h0);
    chk("rst_busy", 32'(mdu_busy), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    cyc();
    clr();
    rst_n = 1;
    #1;
    chk("idle_we", 32'(we_v), 32'h1f);
    cyc();
    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    lw_x5_add();
    id_rs_used = 2'b10;
    #1 chk("lu_unused_we", 32'(we_v), 32'h1f);
    id_rs_used = 2'b11; ex_rd = 5'd0; id_rs = '0;
    #1 chk("lu_x0_we", 32'(we_v), 32'h1f);
    lw_x5_add();
    #1 chk("lu_we", 32'(we_v), 32'b00111);
    chk("lu_fl", 32'(fl_v), 32'b0100);
    cyc();
    clr();
    mem_valid = 1; mem_rd = 5'd5; mem_regwrite = 1;
    #1 chk("lu_bubble_we", 32'(we_v), 32'h1f);
    cyc();
    clr();
    wb_valid = 1; wb_rd = 5'd5; wb_regwrite = 1;
    ex_valid = 1; ex_regwrite = 1; ex_rd = 5'd6; ex_rs = {5'd1, 5'd5};
    #1 chk("lu_fwd_wb", 32'(fwd_sel), 32'b0001);
    cyc();
    // forwarding priority
    clr();
    mem_valid = 1; mem_rd = 5'd3; mem_regwrite = 1;
    wb_valid = 1; wb_rd = 5'd3; wb_regwrite = 1;
    ex_rs = {5'd0, 5'd3};
    #1 chk("fwd_mem_rs0", 32'(fwd_sel), 32'b0010);
    ex_rs = {5'd3, 5'd0};
    #1 chk("fwd_mem_rs1", 32'(fwd_sel), 32'b1000);
    mem_regwrite = 0; ex_rs = {5'd0, 5'd3};
    #1 chk("fwd_wb_rs0", 32'(fwd_sel), 32'b0001);
    wb_rd = 5'd0; mem_regwrite = 1; mem_rd = 5'd0; ex_rs = '0;
    #1 chk("fwd_x0", 32'(fwd_sel), 32'b0000);
    cyc();
    // MDU occupancy
    clr();
    ex_valid = 1; ex_is_mdu = 1;
    busy_n = 0; fl_n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      busy_n += int'(mdu_busy);
      fl_n += int'(ex_mem_flush);
      if (i < 7) chk("mdu_we", 32'(we_v), 32'b00011);
      if (i == 7) chk("mdu_rel_we", 32'(we_v), 32'h1f);
      if (i == 7) chk("mdu_rel_fl", 32'(fl_v), 32'h0);
      cyc();
      clr();
    end
    chk("mdu_busy_cycles", 32'(busy_n), 32'd8);
    chk("mdu_flush_cycles", 32'(fl_n), 32'd7);
    // dmem wait with a held branch, timeout 2
    clr();
    dmem_req = 1; br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_we", 32'(we_v), 32'b00001);
      chk("mw_fl", 32'(fl_v), 32'b0001);
      chk("mw_err", 32'(mem_err), (i == 2) ? 32'd1 : 32'd0);
      cyc();
    end
    dmem_ready = 1;
    #1 chk("mw_rel_we", 32'(we_v), 32'h1f);
    chk("mw_rel_fl", 32'(fl_v), 32'b1100);
    cyc();
    clr();
    #1 chk("mw_err_sticky", 32'(mem_err), 32'd1);
    cyc();
    // branch overrides load-use
    lw_x5_add();
    br_taken = 1;
    #1 chk("br_lu_we", 32'(we_v), 32'h1f);
    chk("br_lu_fl", 32'(fl_v), 32'b1100);
    cyc();
    clr();
`ifdef PERF_CNT_EN
    exp_stall = 11; exp_flush = 2;
`else
    exp_stall = 0; exp_flush = 0;
`endif
    #1 chk("perf_stall", perf_stall, 32'(exp_stall));
    chk("perf_flush", perf_flush, 32'(exp_flush));
    // reset during MDU occupancy
    ex_valid = 1; ex_is_mdu = 1;
    cyc();
    clr();
    cyc(); cyc(); cyc();
    #1 chk("mdu4_busy", 32'(mdu_busy), 32'd1);
    rst_n = 0;
    #1 chk("rstmid_busy", 32'(mdu_busy), 32'd0);
    chk("rstmid_we", 32'(we_v), 32'h1f);
    chk("rstmid_err", 32'(mem_err), 32'd0);
    cyc();
    rst_n = 1;
    #1 chk("post_rst_busy", 32'(mdu_busy), 32'd0);
    chk("post_rst_we", 32'(we_v), 32'h1f);
    cyc();
    chk("post_rst_busy2", 32'(mdu_busy), 32'd0);
    chk("post_rst_perf", perf_stall, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
